ram_bank_reader: RTL and testbench

RAM_BANK_READER -- requirements
Module: ram_bank_reader

---
 rtl/ram_bank_reader.sv | 136 +++++++++++++
 tb/tb_ram_bank_reader.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank_reader.sv
// Double-buffer reader: drains a filled RAM bank one word at a time to a valid/ready consumer.
// Build option: define RAM_BANK_READER_OVF_EN to add sticky overrun detection on ovf_err.
module ram_bank_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bank_full_1,
    input  logic                  bank_full_2,
    input  logic [DATA_WIDTH-1:0] ram_data_1,
    input  logic [DATA_WIDTH-1:0] ram_data_2,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  rd_en_1,
    output logic                  rd_en_2,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  bank_done,
    output logic                  read_bank,
    output logic                  ovf_err,
    output logic [2:0]            state_dbg,
    output logic [1:0]            pend_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    pend_1;
    logic                    pend_2;
    logic                    sel_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    load_out;
    logic                    accept;
    logic                    clear_pend;

    // Handshake: a word transfers on a rising edge where out_valid and out_ready are both high;
    // while out_valid is high and out_ready is low, out_data and out_valid do not change.
    always_comb begin
        state_next = state;
        sel_next   = read_bank;
        addr_next  = ram_addr;
        load_out   = 1'b0;
        accept     = 1'b0;
        clear_pend = 1'b0;
        case (state)
            IDLE: begin
                if (pend_1 || pend_2) begin
                    state_next = FETCH;
                    addr_next  = '0;
                    // Both pending: alternate away from the bank read last.
                    if (pend_1 && pend_2) sel_next = ~read_bank;
                    else                  sel_next = pend_2;
                end
            end
            FETCH: state_next = LATCH;
            LATCH: begin
                state_next = HOLD;
                load_out   = 1'b1;
            end
            HOLD: begin
                if (out_ready) begin
                    accept = 1'b1;
                    if (ram_addr == '1) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = ram_addr + ADDR_WIDTH'(1);
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                clear_pend = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            read_bank <= 1'b1;
            ram_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            pend_1    <= 1'b0;
            pend_2    <= 1'b0;
        end else begin
            state     <= state_next;
            read_bank <= sel_next;
            ram_addr  <= addr_next;
            if (load_out) begin
                out_data  <= read_bank ? ram_data_2 : ram_data_1;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            // A new full pulse wins over the clear issued in DONE.
            pend_1 <= bank_full_1 | (pend_1 & ~(clear_pend & ~read_bank));
            pend_2 <= bank_full_2 | (pend_2 & ~(clear_pend & read_bank));
        end
    end

    assign rd_en_1   = (state == FETCH) && !read_bank;
    assign rd_en_2   = (state == FETCH) && read_bank;
    assign bank_done = (state == DONE);
    assign state_dbg = state;
    assign pend_dbg  = {pend_2, pend_1};

`ifdef RAM_BANK_READER_OVF_EN
    logic busy_1;
    logic busy_2;
    assign busy_1 = (state != IDLE) && !read_bank;
    assign busy_2 = (state != IDLE) && read_bank;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err <= 1'b0;
        end else if ((bank_full_1 && (pend_1 || busy_1)) ||
                     (bank_full_2 && (pend_2 || busy_2))) begin
            ovf_err <= 1'b1;
        end
    end
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bank_reader.sv
// Bench for ram_bank_reader: behavioural RAM banks, bank-level order model and word scoreboard.
module tb_ram_bank_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
`ifdef RAM_BANK_READER_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bank_full_1 = 1'b0;
    logic          bank_full_2 = 1'b0;
    logic [DW-1:0] ram_data_1 = '0;
    logic [DW-1:0] ram_data_2 = '0;
    logic [AW-1:0] ram_addr;
    logic          rd_en_1;
    logic          rd_en_2;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          bank_done;
    logic          read_bank;
    logic          ovf_err;
    logic [2:0]    state_dbg;
    logic [1:0]    pend_dbg;

    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];
    logic [DW-1:0] exp_q [$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   rd1_cnt = 0;
    int   rd2_cnt = 0;
    int   words_in_bank = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    logic prev_stall = 1'b0;
    logic prev_done = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic last_bank = 1'b1;

    ram_bank_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .bank_full_1(bank_full_1), .bank_full_2(bank_full_2),
        .ram_data_1(ram_data_1), .ram_data_2(ram_data_2),
        .ram_addr(ram_addr), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bank_done(bank_done), .read_bank(read_bank), .ovf_err(ovf_err),
        .state_dbg(state_dbg), .pend_dbg(pend_dbg)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM banks, one cycle of latency.
    always @(posedge clk) begin
        if (rd_en_1) ram_data_1 <= mem1[ram_addr];
        if (rd_en_2) ram_data_2 <= mem2[ram_addr];
    end

    // Per-cycle observation, sampled mid-cycle.
    task automatic monitor();
        cyc++;
        if (reset) begin
            words_in_bank = 0;
            prev_stall = 1'b0;
            prev_done = 1'b0;
        end else begin
            checks++;
            if (rd_en_1 && rd_en_2) begin
                errors++;
                $display("FAIL rd_en_overlap: rd_en_1=%0b rd_en_2=%0b, required not both", rd_en_1, rd_en_2);
            end
            if (rd_en_1) rd1_cnt++;
            if (rd_en_2) rd2_cnt++;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (rd_en_1 || rd_en_2) begin
                    errors++;
                    $display("FAIL rd_during_stall: rd_en_1=%0b rd_en_2=%0b, required 0", rd_en_1, rd_en_2);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h, required no word", out_data);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL word: got %h, required %h", out_data, e);
                    end
                end
                if (words_in_bank == 0) first_cyc = cyc;
                last_cyc = cyc;
                words_in_bank++;
            end
            if (bank_done) begin
                checks++;
                if (prev_done || words_in_bank != DEPTH) begin
                    errors++;
                    $display("FAIL bank_done: prev_done=%0b words=%0d, required 0 and %0d", prev_done, words_in_bank, DEPTH);
                end
                done_cnt++;
                words_in_bank = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_done = bank_done;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic f1, input logic f2);
        bank_full_1 = f1;
        bank_full_2 = f2;
        step();
        bank_full_1 = 1'b0;
        bank_full_2 = 1'b0;
    endtask

    task automatic push_bank(input logic b);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(b ? mem2[i] : mem1[i]);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] = DW'($urandom_range(0, 255));
            mem2[i] = DW'($urandom_range(0, 255));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        bank_full_1 = 1'b0;
        bank_full_2 = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_q.delete();
        last_bank = 1'b1;
    endtask

    task automatic wait_dones(input int target, input logic rand_ready);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL done_timeout: dones=%0d, required %0d", done_cnt, target);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL words_left: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL reset_out: valid=%0b data=%h addr=%0d, required 0 0 0", out_valid, out_data, ram_addr);
        end
        checks++;
        if (rd_en_1 !== 1'b0 || rd_en_2 !== 1'b0 || bank_done !== 1'b0 || ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: rd1=%0b rd2=%0b done=%0b ovf=%0b, required 0", rd_en_1, rd_en_2, bank_done, ovf_err);
        end
        checks++;
        if (read_bank !== 1'b1 || state_dbg !== ST_IDLE || pend_dbg !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: read_bank=%0b state=%0d pend=%b, required 1 0 00", read_bank, state_dbg, pend_dbg);
        end
        reset = 1'b0;
        last_bank = 1'b1;
    endtask

    task automatic test_single_bank();
        int d0 = done_cnt;
        int r1 = rd1_cnt;
        int r2 = rd2_cnt;
        for (int i = 0; i < DEPTH; i++) mem1[i] = DW'(i);
        out_ready = 1'b1;
        push_bank(1'b0);
        pulse(1'b1, 1'b0);
        last_bank = 1'b0;
        wait_dones(d0 + 1, 1'b0);
        checks++;
        if (rd2_cnt != r2 || rd1_cnt - r1 != DEPTH) begin
            errors++;
            $display("FAIL single_rd_en: rd1=%0d rd2=%0d, required %0d 0", rd1_cnt - r1, rd2_cnt - r2, DEPTH);
        end
        checks++;
        if (last_cyc - first_cyc != 3 * (DEPTH - 1)) begin
            errors++;
            $display("FAIL throughput: span=%0d cycles, required %0d", last_cyc - first_cyc, 3 * (DEPTH - 1));
        end
        checks++;
        if (read_bank !== 1'b0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL single_end: read_bank=%0b dones=%0d, required 0 1", read_bank, done_cnt - d0);
        end
    endtask

    task automatic test_both_banks();
        int d0;
        do_reset();
        d0 = done_cnt;
        fill_random();
        push_bank(1'b0);
        push_bank(1'b1);
        pulse(1'b1, 1'b1);
        last_bank = 1'b1;
        wait_dones(d0 + 2, 1'b0);
        checks++;
        if (pend_dbg !== 2'b00 || read_bank !== 1'b1 || done_cnt != d0 + 2) begin
            errors++;
            $display("FAIL both_end: pend=%b read_bank=%0b dones=%0d, required 00 1 2", pend_dbg, read_bank, done_cnt - d0);
        end
    endtask

    task automatic test_stall();
        int d0;
        int stall = 0;
        int n = 0;
        do_reset();
        d0 = done_cnt;
        fill_random();
        push_bank(1'b0);
        out_ready = 1'b1;
        pulse(1'b1, 1'b0);
        last_bank = 1'b0;
        while (done_cnt < d0 + 1 && n < 500) begin
            if (out_valid && words_in_bank == 5 && stall < 10) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                if (stall == 10) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== mem1[5]) begin
                        errors++;
                        $display("FAIL stall_word: valid=%0b data=%h, required 1 %h", out_valid, out_data, mem1[5]);
                    end
                    stall++;
                end
                out_ready = 1'b1;
            end
            step();
            n++;
        end
        wait_dones(d0 + 1, 1'b0);
        checks++;
        if (stall != 11) begin
            errors++;
            $display("FAIL stall_count: %0d, required 11", stall);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        fill_random();
        push_bank(1'b0);
        out_ready = 1'b1;
        pulse(1'b1, 1'b0);
        while (!(state_dbg == ST_HOLD && ram_addr == AW'(7)) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (state_dbg !== ST_HOLD || ram_addr !== AW'(7)) begin
            errors++;
            $display("FAIL mid_reach: state=%0d addr=%0d, required 3 7", state_dbg, ram_addr);
        end
        out_ready = 1'b0;
        reset = 1'b1;
        bank_full_2 = 1'b1;
        step();
        reset = 1'b0;
        bank_full_2 = 1'b0;
        exp_q.delete();
        last_bank = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || ram_addr !== '0 || state_dbg !== ST_IDLE || pend_dbg !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: valid=%0b addr=%0d state=%0d pend=%b, required 0 0 0 00", out_valid, ram_addr, state_dbg, pend_dbg);
        end
        repeat (4) step();
        checks++;
        if (state_dbg !== ST_IDLE || rd_en_1 !== 1'b0 || rd_en_2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: state=%0d rd1=%0b rd2=%0b, required 0 0 0", state_dbg, rd_en_1, rd_en_2);
        end
    endtask

    task automatic test_ovf();
        int d0;
        do_reset();
        d0 = done_cnt;
        fill_random();
        push_bank(1'b0);
        out_ready = 1'b1;
        pulse(1'b1, 1'b0);
        repeat (10) step();
        pulse(1'b1, 1'b0);
        last_bank = 1'b0;
        checks++;
        if (ovf_err !== OVF_EXP) begin
            errors++;
            $display("FAIL ovf_set: got %0b, required %0b", ovf_err, OVF_EXP);
        end
        wait_dones(d0 + 1, 1'b1);
        repeat (20) step();
        checks++;
        if (ovf_err !== OVF_EXP || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%0b dones=%0d, required %0b 1", ovf_err, done_cnt - d0, OVF_EXP);
        end
        do_reset();
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_reset: got %0b, required 0", ovf_err);
        end
    endtask

    task automatic test_refill_at_done();
        int d0;
        int n = 0;
        do_reset();
        d0 = done_cnt;
        fill_random();
        push_bank(1'b1);
        out_ready = 1'b1;
        pulse(1'b0, 1'b1);
        while (state_dbg != ST_DONE && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (state_dbg !== ST_DONE || read_bank !== 1'b1) begin
            errors++;
            $display("FAIL refill_reach: state=%0d read_bank=%0b, required 4 1", state_dbg, read_bank);
        end
        push_bank(1'b1);
        pulse(1'b0, 1'b1);
        last_bank = 1'b1;
        checks++;
        if (pend_dbg[1] !== 1'b1) begin
            errors++;
            $display("FAIL refill_pend: pend_2=%0b, required 1", pend_dbg[1]);
        end
        wait_dones(d0 + 2, 1'b1);
        checks++;
        if (pend_dbg !== 2'b00 || read_bank !== 1'b1 || ovf_err !== OVF_EXP) begin
            errors++;
            $display("FAIL refill_end: pend=%b read_bank=%0b ovf=%0b, required 00 1 %0b", pend_dbg, read_bank, ovf_err, OVF_EXP);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int d0 = done_cnt;
            int pat = $urandom_range(1, 3);
            int nb;
            logic first;
            fill_random();
            if (pat == 3) begin
                first = ~last_bank;
                push_bank(first);
                push_bank(~first);
                last_bank = ~first;
                nb = 2;
                pulse(1'b1, 1'b1);
            end else begin
                first = (pat == 2);
                push_bank(first);
                last_bank = first;
                nb = 1;
                pulse(pat == 1, pat == 2);
            end
            wait_dones(d0 + nb, 1'b1);
            checks++;
            if (read_bank !== last_bank || pend_dbg !== 2'b00) begin
                errors++;
                $display("FAIL random_round%0d: read_bank=%0b pend=%b, required %0b 00", r, read_bank, pend_dbg, last_bank);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_bank();
        test_both_banks();
        test_stall();
        test_reset_mid();
        test_ovf();
        test_refill_at_done();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
